cmd_receiver: RTL and testbench
===============================

// Module: cmd_receiver
// PURPOSE
//  Upstream command/data stage between the UART receiver and the vector coprocessor.
//  Parses the incoming byte stream into commands:
//   - vector-load commands write NUM_ELEM bytes into vector memory A or B;
//   - operation commands latch op and pulse calc_start.
//  Holds op until the transmit stage reports op_finished, then returns op to idle (0x00).
// PARAMETERS
//  NUM_ELEM     1024      bytes per vector load; ADDR_W = $clog2(NUM_ELEM)
//  TIMEOUT_CYC  5_000_000 idle cycles allowed between bytes of a vector load before abort
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst_n        in   1       asynchronous reset, active low
//  rx_data      in   8       byte from UART receiver
//  rx_ready     in   1       1-cycle strobe: rx_data valid this cycle
//  op_finished  in   1       1-cycle strobe from transmit stage: result fully sent
//  wr_en        out  1       vector memory write strobe
//  wr_sel       out  1       0 = vector A, 1 = vector B
//  wr_addr      out  ADDR_W  element index
//  wr_data      out  8       element value
//  op           out  8       current operation code, 0x00 = idle
//  calc_start   out  1       1-cycle pulse: vectors and op ready, start calculation
//  busy         out  1       1 whenever state != IDLE
//  load_err     out  1       1-cycle pulse: vector load aborted by timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; op=0x00; element counter=0;
//   timeout counter=0. Reset mid-load or mid-wait aborts immediately.
//  Command codes:
//   - 0x01 load A; 0x02 load B.
//   - 0x03..0x07 operations (sum, avg, manDist, dot, euclid); op carries the code.
//   - Any other code is ignored; stay IDLE.
//  FSM:
//   IDLE:
//    - rx_ready & code 0x01/0x02 -> LOAD; wr_sel<=code[1]; counter<=0.
//    - rx_ready & code 0x03..0x07 -> START; op<=rx_data.
//   LOAD (each rx_ready):
//    - wr_en=1 next cycle; wr_addr=counter; wr_data=byte; counter+=1.
//    - Byte with counter==NUM_ELEM-1 written, then -> IDLE. No wrap: exactly NUM_ELEM writes.
//    - Timeout counter clears on every rx_ready and increments otherwise.
//    - Reaching TIMEOUT_CYC-1 -> IDLE with load_err pulse. Memory is left partially written.
//   START: calc_start=1 for exactly one cycle -> WAIT_DONE.
//   WAIT_DONE:
//    - rx_ready bytes are dropped: no writes, no op change.
//    - op_finished -> op<=0x00, -> IDLE.
//  Latency and strobes:
//   - rx_ready to wr_en: 1 cycle, registered outputs.
//   - Op byte to calc_start: 2 cycles (IDLE->START, START asserts).
//   - wr_en, calc_start and load_err are single-cycle and never asserted together.
//  Simultaneous events:
//   - op_finished outside WAIT_DONE is ignored.
//   - rx_ready in the same cycle as a timeout: timeout wins and the byte is dropped.
//   - Back-to-back rx_ready on consecutive cycles must be accepted with no loss.
//  Widths: counter is ADDR_W+1 bits so the NUM_ELEM terminal count compares without overflow.
// TESTING
//  1. rst_n=0 mid-LOAD after 10 bytes -> outputs 0, op=0x00, busy=0. Next 0x01 restarts at wr_addr 0.
//  2. 0x01 then bytes 0..1023 (val=addr%256) -> 1024 wr_en, wr_sel=0, addr 0..1023, busy=0 after last.
//  3. 0x02 then 1024 bytes sent on consecutive cycles -> all written, wr_sel=1, none lost.
//  4. 0x05 -> op=0x05 one cycle later; calc_start pulse next cycle. Extra bytes ignored;
//     op_finished -> op=0x00, IDLE.
//  5. 0x01 + 3 bytes, then silence TIMEOUT_CYC (bench overrides to 100) -> load_err pulse, IDLE.
//     Next 0x01 restarts at addr 0.
//  6. Unknown code 0xAA and a stray op_finished in IDLE -> no output activity, busy stays 0.

Source files
------------

// File: rtl/cmd_receiver.sv
// Command/data stage between the UART receiver and the vector coprocessor.
// Parses the byte stream into vector-load and operation commands.
module cmd_receiver #(
  parameter int unsigned NUM_ELEM    = 1024,
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  localparam int unsigned ADDR_W     = $clog2(NUM_ELEM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              op_finished,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        op,
  output logic              calc_start,
  output logic              busy,
  output logic              load_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEM - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                wr_en_q;
  logic                wr_sel_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;
  logic [7:0]          op_q;
  logic                calc_start_q;
  logic                load_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      op_q         <= '0;
      calc_start_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      calc_start_q <= 1'b0;
      load_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_ready) begin
            if (rx_data == 8'h01 || rx_data == 8'h02) begin
              state_q  <= LOAD;
              wr_sel_q <= rx_data[1];
              cnt_q    <= '0;
              tmo_q    <= '0;
            end else if (rx_data >= 8'h03 && rx_data <= 8'h07) begin
              state_q <= START;
              op_q    <= rx_data;
            end
          end
        end
        LOAD: begin
          // Timeout is checked first so a byte arriving on the abort cycle is dropped.
          if (tmo_q == TMO_LAST) begin
            state_q    <= IDLE;
            load_err_q <= 1'b1;
            tmo_q      <= '0;
          end else if (rx_ready) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q[ADDR_W-1:0];
            wr_data_q <= rx_data;
            cnt_q     <= cnt_q + 1'b1;
            tmo_q     <= '0;
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        START: begin
          calc_start_q <= 1'b1;
          state_q      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (op_finished) begin
            op_q    <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign op         = op_q;
  assign calc_start = calc_start_q;
  assign load_err   = load_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_receiver.sv
// Self-checking bench for cmd_receiver: per-cycle model comparison plus
// directed scenarios with hand-computed expectations.
module tb_cmd_receiver;

  localparam int unsigned N = 1024;
  localparam int unsigned T = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       op_finished = 1'b0;
  logic       wr_en, wr_sel, calc_start, busy, load_err;
  logic [9:0] wr_addr;
  logic [7:0] wr_data, op;

  cmd_receiver #(.NUM_ELEM(N), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .op_finished(op_finished), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .op(op), .calc_start(calc_start), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the outputs must be after each edge, from the command rules.
  bit         m_load, m_pend, m_wait, m_sel;
  int         m_next, m_quiet;
  logic [7:0] m_op;
  bit         e_wr, e_calc, e_err;
  int         e_addr;
  logic [7:0] e_data;

  initial begin
    m_load = 0; m_pend = 0; m_wait = 0; m_sel = 0; m_next = 0; m_quiet = 0;
    m_op = 8'h00; e_wr = 0; e_calc = 0; e_err = 0; e_addr = 0; e_data = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_load = 0; m_pend = 0; m_wait = 0; m_sel = 0; m_op = 8'h00;
        e_wr = 0; e_calc = 0; e_err = 0;
      end else begin
        e_wr = 0; e_calc = 0; e_err = 0;
        if (m_load) begin
          if (m_quiet == int'(T) - 1) begin
            m_load = 0;
            e_err  = 1;
          end else if (rx_ready) begin
            e_wr = 1; e_addr = m_next; e_data = rx_data;
            m_next++;
            m_quiet = 0;
            if (m_next == int'(N)) m_load = 0;
          end else begin
            m_quiet++;
          end
        end else if (m_pend) begin
          e_calc = 1; m_pend = 0; m_wait = 1;
        end else if (m_wait) begin
          if (op_finished) begin
            m_wait = 0; m_op = 8'h00;
          end
        end else if (rx_ready) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            m_load = 1; m_sel = (rx_data == 8'h02); m_next = 0; m_quiet = 0;
          end else if (rx_data >= 8'h03 && rx_data <= 8'h07) begin
            m_op = rx_data; m_pend = 1;
          end
        end
      end
    end
  end

  int n_wr, n_calc, n_err, first_addr, last_addr;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("calc_start", 32'(calc_start), 32'(e_calc));
        chk("load_err", 32'(load_err), 32'(e_err));
        chk("op", 32'(op), 32'(m_op));
        chk("busy", 32'(busy), 32'(m_load | m_pend | m_wait));
        chk("wr_sel", 32'(wr_sel), 32'(m_sel));
        chk("pulse_excl", 32'((32'(wr_en) + 32'(calc_start) + 32'(load_err)) <= 1), 32'd1);
        if (e_wr && wr_en) begin
          chk("wr_addr", 32'(wr_addr), 32'(e_addr));
          chk("wr_data", 32'(wr_data), 32'(e_data));
        end
        if (wr_en) begin
          if (n_wr == 0) first_addr = int'(wr_addr);
          last_addr = int'(wr_addr);
          n_wr++;
        end
        if (calc_start) n_calc++;
        if (load_err) n_err++;
      end
    end
  end

  task automatic clr();
    n_wr = 0; n_calc = 0; n_err = 0; first_addr = -1; last_addr = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_calc", 32'(calc_start), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_wr_sel", 32'(wr_sel), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    clr();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-load, then restart.
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h40));
    #1;
    chk("t1_writes", 32'(n_wr), 32'd10);
    pulse_rst();
    clr();
    send_byte(8'h01);
    send_byte(8'h5A);
    #1;
    chk("t1_restart_addr", 32'(first_addr), 32'd0);
    chk("t1_restart_data", 32'(wr_data), 32'h5A);
    pulse_rst();

    // Full load of vector A with gaps.
    clr();
    send_byte(8'h01);
    for (int i = 0; i < int'(N); i++) send_byte(8'(i));
    #1;
    chk("t2_writes", 32'(n_wr), 32'd1024);
    chk("t2_first", 32'(first_addr), 32'd0);
    chk("t2_last", 32'(last_addr), 32'd1023);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_sel", 32'(wr_sel), 32'd0);

    // Back-to-back load of vector B.
    clr();
    send_byte(8'h02);
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      rx_data  = 8'(i * 7 + 3);
      rx_ready = 1'b1;
    end
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    chk("t3_writes", 32'(n_wr), 32'd1024);
    chk("t3_last", 32'(last_addr), 32'd1023);
    chk("t3_sel", 32'(wr_sel), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);

    // Operation command.
    clr();
    send_byte(8'h05);
    #1;
    chk("t4_op", 32'(op), 32'h05);
    chk("t4_calc_early", 32'(calc_start), 32'd0);
    @(negedge clk);
    #1;
    chk("t4_calc", 32'(calc_start), 32'd1);
    send_byte(8'h01);
    send_byte(8'h33);
    #1;
    chk("t4_dropped", 32'(n_wr), 32'd0);
    chk("t4_op_hold", 32'(op), 32'h05);
    chk("t4_busy", 32'(busy), 32'd1);
    @(negedge clk);
    op_finished = 1'b1;
    @(negedge clk);
    op_finished = 1'b0;
    #1;
    chk("t4_op_idle", 32'(op), 32'h00);
    chk("t4_busy_idle", 32'(busy), 32'd0);
    chk("t4_calc_cnt", 32'(n_calc), 32'd1);

    // Timeout abort.
    clr();
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h12);
    found = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      #1;
      if (load_err) begin
        found = i;
        break;
      end
    end
    chk("t5_latency", 32'(found), 32'd100);
    chk("t5_writes", 32'(n_wr), 32'd3);
    chk("t5_busy", 32'(busy), 32'd0);

    // Restart, then a byte landing exactly on the abort cycle.
    clr();
    send_byte(8'h01);
    send_byte(8'h77);
    #1;
    chk("t5_restart_addr", 32'(first_addr), 32'd0);
    repeat (99) @(negedge clk);
    rx_data  = 8'hEE;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    chk("t5_collide_err", 32'(load_err), 32'd1);
    chk("t5_collide_writes", 32'(n_wr), 32'd1);

    // Unknown code and stray op_finished.
    clr();
    send_byte(8'hAA);
    @(negedge clk);
    op_finished = 1'b1;
    @(negedge clk);
    op_finished = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_activity", 32'(n_wr + n_calc + n_err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_op", 32'(op), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
